pipelined_rca: RTL

- Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake.
- Successor to the fixed 4-bit combinational RCA.
- Splits a WIDTH-bit add into CHUNK-bit slices; one slice resolves per clock, and the carry is registered between slices.
- Feeds the SHA-256 round datapath, where mod-2^32 additions must close timing at full clock rate with one result per cycle.

---
 rtl/full_adder.sv | 19 +
 rtl/rca_slice.sv | 31 +++
 rtl/pipelined_rca.sv | 120 ++++++++++++
 3 files changed

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple chain.
// Ports:
//   i_a, i_b  - addend bits
//   i_carry   - carry-in
//   o_summ    - sum bit
//   o_carry   - carry-out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_summ,
    output logic o_carry
);
    logic p;

    assign p       = i_a ^ i_b;
    assign o_summ  = p ^ i_carry;
    assign o_carry = (i_a & i_b) | (i_carry & p);
endmodule

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Ports:
//   i_a, i_b  - CHUNK-bit operand slices
//   i_carry   - carry into the LSB
//   o_summ    - CHUNK-bit sum slice
//   o_carry   - carry out of the MSB
module rca_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_carry,
    output logic [CHUNK-1:0] o_summ,
    output logic             o_carry
);
    logic [CHUNK:0] c;

    assign c[0] = i_carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .i_a     (i_a[i]),
            .i_b     (i_b[i]),
            .i_carry (c[i]),
            .o_summ  (o_summ[i]),
            .o_carry (c[i+1])
        );
    end

    assign o_carry = c[CHUNK];
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// A WIDTH-bit add is split into STAGES = WIDTH/CHUNK slices; stage k resolves
// slice k and registers the carry for stage k+1. All stages advance together
// whenever the output register is empty or being drained.
// Ports:
//   i_clk, i_rst_n    - clock, asynchronous active-low reset
//   i_valid, o_ready  - operand handshake (o_ready depends only on i_ready/state)
//   i_a, i_b, i_carry - operands and carry-in
//   i_sub             - 1: A + ~B + (i_carry ^ 1), i.e. A - B - i_carry
//   o_valid, i_ready  - result handshake
//   o_summ, o_carry   - WIDTH-bit result and MSB carry-out (1 = no borrow in sub)
module pipelined_rca #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_summ,
    output logic             o_carry
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipelined_rca: WIDTH must be a positive multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage registers. a_q/b_q carry the operands forward as the skew
    // buffer; only the slices above stage k are consumed downstream.
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q, vld_pipe;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [STAGES-1:0] c_d, vld_d;

    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;
    assign b_eff   = i_b ^ {WIDTH{i_sub}};
    assign cin_eff = i_carry ^ i_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src, b_src, s_src, s_nxt;
        logic             c_src, v_src;
        logic [CHUNK-1:0] slc_sum;
        logic             slc_co;

        if (k == 0) begin : g_head
            assign a_src = i_a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = cin_eff;
            assign v_src = i_valid;
        end else begin : g_body
            assign a_src = a_q[k-1];
            assign b_src = b_q[k-1];
            assign s_src = s_q[k-1];
            assign c_src = c_q[k-1];
            assign v_src = vld_pipe[k-1];
        end

        rca_slice #(.CHUNK(CHUNK)) u_slice (
            .i_a     (a_src[k*CHUNK +: CHUNK]),
            .i_b     (b_src[k*CHUNK +: CHUNK]),
            .i_carry (c_src),
            .o_summ  (slc_sum),
            .o_carry (slc_co)
        );

        // Lower slices pass through unchanged; slice k gets this stage's sum.
        always_comb begin
            s_nxt                   = s_src;
            s_nxt[k*CHUNK +: CHUNK] = slc_sum;
        end

        assign a_d[k]   = a_src;
        assign b_d[k]   = b_src;
        assign s_d[k]   = s_nxt;
        assign c_d[k]   = slc_co;
        assign vld_d[k] = v_src;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            vld_pipe <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q      <= c_d;
            vld_pipe <= vld_d;
        end
    end

    // The last stage's operand copy has no consumer.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign o_valid = vld_pipe[STAGES-1];
    assign o_summ  = s_q[STAGES-1];
    assign o_carry = c_q[STAGES-1];
endmodule
